// File: rtl/pulse_burst_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pulse_burst_gen                                             |
// | Function : Triggered burst generator. A start front launches a         |
// |            programmable delay followed by nburst pulses of len ticks   |
// |            separated by gap ticks. Durations count clocks with ce=1.   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pulse_burst_gen #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic              abort,
  input  logic              retrig_en,
  input  logic [WIDTH-1:0]  dly,
  input  logic [WIDTH-1:0]  len,
  input  logic [WIDTH-1:0]  gap,
  input  logic [CWIDTH-1:0] nburst,
  output logic              y,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  q,
  output logic [CWIDTH-1:0] pcnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_HIGH  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  C_Q_ONE = WIDTH'(1);
  localparam logic [CWIDTH-1:0] C_P_ONE = CWIDTH'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  w_q_nxt;
  logic [CWIDTH-1:0] r_pcnt;
  logic [CWIDTH-1:0] w_pcnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_startd;
  logic [WIDTH-1:0]  r_dly;
  logic [WIDTH-1:0]  r_len;
  logic [WIDTH-1:0]  r_gap;
  logic [CWIDTH-1:0] r_nburst;
  logic              w_front;
  logic              w_accept;
  logic              w_load;
  logic [WIDTH-1:0]  w_q_inc;
  logic [CWIDTH-1:0] w_pcnt_inc;

  // Front detection uses the raw inputs; a zero-length pulse or empty burst
  // is never launched, and a busy block only restarts when retriggering is on.
  assign w_front    = start & ~r_startd;
  assign w_accept   = w_front & (len != '0) & (nburst != '0)
                    & ((r_state == S_IDLE) | retrig_en);
  assign w_load     = w_accept & ~abort;
  // Phase end is detected as q+1 == limit, which never wraps inside a phase
  // because q stops one short of the latched limit.
  assign w_q_inc    = r_q + C_Q_ONE;
  assign w_pcnt_inc = r_pcnt + C_P_ONE;

  // Start history register, running on every clock regardless of ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_startd <= 1'b0;
    end else begin
      r_startd <= start;
    end
  end

  // Shadow copies of the timing inputs, captured only on an accepted front.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly    <= '0;
      r_len    <= '0;
      r_gap    <= '0;
      r_nburst <= '0;
    end else if (w_load) begin
      r_dly    <= dly;
      r_len    <= len;
      r_gap    <= gap;
      r_nburst <= nburst;
    end
  end

  // FSM and counter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_pcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: abort beats a front, a front beats ce-gated counting.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_pcnt_nxt  = r_pcnt;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_q_nxt     = '0;
      w_pcnt_nxt  = '0;
    end else if (w_accept) begin
      w_q_nxt     = '0;
      w_pcnt_nxt  = '0;
      w_state_nxt = (dly != '0) ? S_DELAY : S_HIGH;
    end else if (ce) begin
      case (r_state)
        S_DELAY: begin
          if (w_q_inc == r_dly) begin
            w_state_nxt = S_HIGH;
            w_q_nxt     = '0;
          end else begin
            w_q_nxt = w_q_inc;
          end
        end
        S_HIGH: begin
          if (w_q_inc == r_len) begin
            w_q_nxt    = '0;
            w_pcnt_nxt = w_pcnt_inc;
            if (w_pcnt_inc == r_nburst) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end else if (r_gap == '0) begin
              w_state_nxt = S_HIGH;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else begin
            w_q_nxt = w_q_inc;
          end
        end
        S_GAP: begin
          if (w_q_inc == r_gap) begin
            w_state_nxt = S_HIGH;
            w_q_nxt     = '0;
          end else begin
            w_q_nxt = w_q_inc;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign y    = (r_state == S_HIGH);
  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign q    = r_q;
  assign pcnt = r_pcnt;

endmodule
`default_nettype wire

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 Parameter WIDTH, default 8: width of dly/len/gap and phase counter q.
REQ-002 Parameter CWIDTH, default 4: width of nburst and pulse counter pcnt.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  count enable; phase durations are measured in clocks with ce=1 (ce-ticks).
REQ-006 start  input  1  trigger; only the rising edge (front) is significant.
REQ-007 abort  input  1  level; terminates any activity.
REQ-008 retrig_en  input  1  1 = a front while busy restarts the burst; 0 = the front is ignored.
REQ-009 dly  input  WIDTH  ce-ticks from front to first pulse.
REQ-010 len  input  WIDTH  pulse high time in ce-ticks.
REQ-011 gap  input  WIDTH  low time between pulses in ce-ticks.
REQ-012 nburst  input  CWIDTH  number of pulses per burst.
REQ-013 y  output  1  pulse output; y = (state==HIGH).
REQ-014 busy  output  1  busy = (state!=IDLE).
REQ-015 done  output  1  registered one-clock strobe at burst completion.
REQ-016 q  output  WIDTH  current phase counter.
REQ-017 pcnt  output  CWIDTH  pulses completed in the current burst.

Function
REQ-018 The block SHALL register start into startd on every clock, independent of ce; front = start & !startd.
REQ-019 The FSM SHALL have states IDLE, DELAY, HIGH and GAP.
REQ-020 On an accepted front, the block SHALL latch dly, len, gap and nburst into shadow registers; mid-burst input changes SHALL have no effect.
REQ-021 Front acceptance:
  - Accepted in IDLE, and in any busy state when retrig_en=1.
  - Ignored when len==0 or nburst==0, or when busy with retrig_en=0.
REQ-022 Accepted front: q<=0, pcnt<=0; next state DELAY if dly!=0, else HIGH; this transition SHALL NOT depend on ce.
REQ-023 DELAY: on each ce, q<=q+1; on ce with q==dly-1, state<=HIGH and q<=0.
REQ-024 HIGH: on each ce, q<=q+1; on ce with q==len-1:
  - pcnt<=pcnt+1 and q<=0.
  - If pcnt+1==nburst: state<=IDLE and done<=1.
  - Else if gap==0: state stays HIGH, so y stays high continuously.
  - Else: state<=GAP.
REQ-025 GAP: on each ce, q<=q+1; on ce with q==gap-1, state<=HIGH and q<=0.
REQ-026 done SHALL be 1 for exactly the one clock following the completing edge and 0 otherwise.
REQ-027 A retrigger in the completing cycle SHALL win: the burst restarts and done is not asserted.
REQ-028 Priority, high to low: rst, abort, accepted front, counting.
REQ-029 abort=1 SHALL force state IDLE, q=0, pcnt=0 and done=0; a front in the same cycle is consumed and discarded.
REQ-030 While ce=0, q, pcnt and state SHALL hold, except for transitions caused by front, abort or rst.
REQ-031 Arithmetic:
  - Counters SHALL be unsigned and SHALL NOT wrap within a phase, because compares use the latched limits.
  - The maximum phase is 2^WIDTH-1 ce-ticks; dly=0 and gap=0 SHALL mean zero-length phases.
REQ-032 y, busy, q and pcnt SHALL be glitch-free registered-state decodes; y SHALL be a single compare of the registered state.

Reset
REQ-033 Reset values: state=IDLE, q=0, pcnt=0, done=0, startd=0, shadow registers=0, y=0, busy=0.
REQ-034 When start is held high through reset release, startd=0 makes it a front; the bench SHALL verify that it is accepted on the first clock after rst deasserts.
REQ-035 rst mid-burst SHALL take effect at the next posedge; y falls in the following cycle and done is not asserted.

Verification
REQ-036 Basic burst: ce=1, dly=2, len=3, gap=1, nburst=2, one front at edge E0 -> y high after E2..E4, low after E5, high after E6..E8; done high only after E9; busy high after E0..E8.
REQ-037 Immediate pulse with merge: ce=1, dly=0, len=4, gap=0, nburst=3 -> y high 12 consecutive clocks starting the clock after the front; pcnt steps 1,2,3; one done strobe.
REQ-038 Clock enable: ce pulses every 8th clock, dly=1, len=2, nburst=1 -> y high for exactly 2 ce-ticks (16 clocks); q changes only on ce clocks.
REQ-039 Retrigger: retrig_en=1, front during the 2nd pulse of REQ-036 -> pcnt returns to 0, the DELAY phase restarts, and the first done occurs only after the new 2-pulse burst; with retrig_en=0, the same front has no effect.
REQ-040 Abort, guard and reset:
  - abort with front in the same cycle during HIGH -> IDLE next clock, y=0, no done.
  - len=0 front -> busy stays 0.
  - rst mid-GAP -> all outputs at reset values.
